// File: rtl/regfile_mp.sv
// regfile_mp: integer register file with a parametrised number of combinational
// read ports and one synchronous write port. Register 0 can be hardwired to
// zero, and a read returns the write data when it hits the address being
// written in the same cycle.
// After every reset a clear sequencer writes zero to each entry, one per cycle.
// While that sweep runs, busy is high, reads return zero and user writes are
// dropped, which wr_drop reports.
// Optional feature macro: REGFILE_PARITY_EN. When it is defined, each entry
// carries an even-parity bit, and a sticky parity_err output is added.
module regfile_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2,
    parameter int ZERO_REG   = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] ra,
    output logic [NUM_READ*DATA_WIDTH-1:0] rd,
    input  logic                           we,
    input  logic [ADDR_WIDTH-1:0]          wa,
    input  logic [DATA_WIDTH-1:0]          wd,
    output logic                           busy,
`ifdef REGFILE_PARITY_EN
    output logic                           parity_err,
`endif
    output logic                           wr_drop
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {CLEAR, READY} state_t;

    state_t                  state_reg;
    logic [ADDR_WIDTH-1:0]   clr_ptr_reg;
    logic                    wr_drop_reg;
    logic [DATA_WIDTH-1:0]   ram [DEPTH];

    logic zero_wa;
    logic user_wr;

    // Writes to a hardwired zero register are silently ignored (legal, not a drop).
    assign zero_wa = (ZERO_REG != 0) && (wa == '0);
    assign user_wr = (state_reg == READY) && we && !zero_wa;
    assign busy    = (state_reg == CLEAR);
    assign wr_drop = wr_drop_reg;

    // Clear sequencer: sweep every entry once after reset, then stay READY.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= CLEAR;
            clr_ptr_reg <= '0;
            wr_drop_reg <= 1'b0;
        end else begin
            wr_drop_reg <= (state_reg == CLEAR) && we;
            if (state_reg == CLEAR) begin
                clr_ptr_reg <= clr_ptr_reg + ADDR_WIDTH'(1);
                if (clr_ptr_reg == LAST_IDX) begin
                    state_reg <= READY;
                end
            end
        end
    end

    // Array write port: the clear write always wins; the reset edge leaves contents alone.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_reg == CLEAR) begin
                ram[clr_ptr_reg] <= '0;
            end else if (user_wr) begin
                ram[wa] <= wd;
            end
        end
    end

`ifdef REGFILE_PARITY_EN
    logic                parity_err_reg;
    logic                par_mem [DEPTH];
    logic [NUM_READ-1:0] par_bad;

    assign parity_err = parity_err_reg;

    // Parity storage: the even-parity bit of wd, or 0 for a cleared entry.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_reg == CLEAR) begin
                par_mem[clr_ptr_reg] <= 1'b0;
            end else if (user_wr) begin
                par_mem[wa] <= ^wd;
            end
        end
    end

    // Sticky error flag: set by any array-sourced read whose parity does not match.
    always_ff @(posedge clk) begin
        if (reset) begin
            parity_err_reg <= 1'b0;
        end else if (|par_bad) begin
            parity_err_reg <= 1'b1;
        end
    end
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_READ; gi++) begin : g_read
            logic [ADDR_WIDTH-1:0] ra_i;
            logic [DATA_WIDTH-1:0] rd_i;
            logic                  zero_hit;
            logic                  byp_hit;

            assign ra_i     = ra[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign zero_hit = (ZERO_REG != 0) && (ra_i == '0);
            assign byp_hit  = we && (wa == ra_i);
            assign rd[gi*DATA_WIDTH +: DATA_WIDTH] = rd_i;

            // Read mux in priority order: busy, zero register, bypass, array.
            always_comb begin
                rd_i = '0;
                if (busy || zero_hit) begin
                    rd_i = '0;
                end else if (byp_hit) begin
                    rd_i = wd;
                end else begin
                    rd_i = ram[ra_i];
                end
            end

`ifdef REGFILE_PARITY_EN
            assign par_bad[gi] = !busy && !zero_hit && !byp_hit &&
                                 (par_mem[ra_i] != ^ram[ra_i]);
`endif
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp. Two instances share one stimulus stream: one has
// ZERO_REG=1 and the other ZERO_REG=0, and both have four read ports. A
// behavioural model is updated on each rising edge and checked on every
// falling edge. Directed steps pin the model with literal values.
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 4;
    localparam int DEPTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [NR*AW-1:0] ra;
    logic             we;
    logic [AW-1:0]    wa;
    logic [DW-1:0]    wd;
    logic [NR*DW-1:0] rd_z, rd_n;
    logic             busy_z, busy_n, drop_z, drop_n;
`ifdef REGFILE_PARITY_EN
    logic             pe_z, pe_n;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .ZERO_REG(1)) dut_z (
        .clk(clk), .reset(reset), .ra(ra), .rd(rd_z), .we(we), .wa(wa), .wd(wd),
        .busy(busy_z),
`ifdef REGFILE_PARITY_EN
        .parity_err(pe_z),
`endif
        .wr_drop(drop_z));

    regfile_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .ZERO_REG(0)) dut_n (
        .clk(clk), .reset(reset), .ra(ra), .rd(rd_n), .we(we), .wa(wa), .wd(wd),
        .busy(busy_n),
`ifdef REGFILE_PARITY_EN
        .parity_err(pe_n),
`endif
        .wr_drop(drop_n));

    // ---------------- behavioural model ----------------
    logic [DW-1:0] mem_z [DEPTH];
    logic [DW-1:0] mem_n [DEPTH];
    int            clear_left = 0;
    bit            model_valid = 0;
    bit            drop_m = 0;

    always @(posedge clk) begin
        if (reset) begin
            clear_left  = DEPTH;
            drop_m      = 0;
            model_valid = 1;
        end else if (model_valid) begin
            if (clear_left > 0) begin
                drop_m = we;
                clear_left--;
                if (clear_left == 0) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        mem_z[i] = '0;
                        mem_n[i] = '0;
                    end
                end
            end else begin
                drop_m = 0;
                if (we) begin
                    if (wa != 0) mem_z[wa] = wd;
                    mem_n[wa] = wd;
                end
            end
        end
    end

    function automatic logic [DW-1:0] model_rd(bit zr, logic [AW-1:0] a);
        if (clear_left > 0) return '0;
        if (zr && a == 0) return '0;
        if (we && wa == a) return wd;
        return zr ? mem_z[a] : mem_n[a];
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (model_valid) begin
            for (int p = 0; p < NR; p++) begin
                logic [AW-1:0] a;
                a = ra[p*AW +: AW];
                check($sformatf("rd_z[%0d]", p), rd_z[p*DW +: DW], model_rd(1, a));
                check($sformatf("rd_n[%0d]", p), rd_n[p*DW +: DW], model_rd(0, a));
            end
            check("busy_z", {31'b0, busy_z}, {31'b0, clear_left > 0});
            check("busy_n", {31'b0, busy_n}, {31'b0, clear_left > 0});
            check("drop_z", {31'b0, drop_z}, {31'b0, drop_m});
            check("drop_n", {31'b0, drop_n}, {31'b0, drop_m});
`ifdef REGFILE_PARITY_EN
            check("parity_err_z", {31'b0, pe_z}, 32'd0);
            check("parity_err_n", {31'b0, pe_n}, 32'd0);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                          input logic [AW-1:0] a2, input logic [AW-1:0] a3);
        ra = {a3, a2, a1, a0};
    endtask

    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (busy_z && cnt < 100) begin
            step();
            cnt++;
        end
    endtask

    int cnt;

    initial begin
        reset = 1; we = 0; wa = '0; wd = '0; ra = '0;
        step();
        reset = 0;
        $display("reset released, sweep started");
        wait_ready(cnt);
        check("sweep_len", cnt, 32'd32);

        set_ra(5'd0, 5'd5, 5'd31, 5'd0);
        #1;
        check("swept_ra0",  rd_z[0*DW +: DW], 32'h0);
        check("swept_ra5",  rd_z[1*DW +: DW], 32'h0);
        check("swept_ra31", rd_n[2*DW +: DW], 32'h0);

        $display("write wa=7 wd=deadbeef");
        we = 1; wa = 5'd7; wd = 32'hDEADBEEF;
        step();
        we = 0;
        set_ra(5'd7, 5'd6, 5'd0, 5'd0);
        #1;
        check("read7", rd_z[0*DW +: DW], 32'hDEADBEEF);
        check("read6", rd_z[1*DW +: DW], 32'h0);

        $display("bypass wa=3 wd=12345678");
        we = 1; wa = 5'd3; wd = 32'h12345678;
        set_ra(5'd3, 5'd3, 5'd3, 5'd3);
        #1;
        check("byp_p0", rd_z[0*DW +: DW], 32'h12345678);
        check("byp_p1", rd_z[1*DW +: DW], 32'h12345678);
        check("byp_p3", rd_n[3*DW +: DW], 32'h12345678);
        step();
        we = 0;
        #1;
        check("after_byp", rd_z[0*DW +: DW], 32'h12345678);

        $display("write wa=0 wd=ffffffff");
        we = 1; wa = 5'd0; wd = 32'hFFFFFFFF;
        set_ra(5'd0, 5'd0, 5'd0, 5'd0);
        #1;
        check("zero_same_z", rd_z[0*DW +: DW], 32'h0);
        check("zero_same_n", rd_n[0*DW +: DW], 32'hFFFFFFFF);
        step();
        we = 0;
        #1;
        check("zero_after_z", rd_z[0*DW +: DW], 32'h0);
        check("zero_after_n", rd_n[0*DW +: DW], 32'hFFFFFFFF);
        check("zero_nodrop",  {31'b0, drop_z}, 32'd0);

        // Random traffic, with occasional resets; the model checks every cycle.
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 79) == 0);
            we    = $urandom_range(0, 1);
            wa    = AW'($urandom_range(0, DEPTH - 1));
            wd    = $urandom;
            for (int p = 0; p < NR; p++) begin
                ra[p*AW +: AW] = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1));
            end
            if (we && !reset) $display("rand %0d: write wa=%0d wd=%h", i, wa, wd);
            step();
        end
        reset = 0; we = 0;

        // A write on the third busy cycle is dropped and pulses wr_drop once.
        reset = 1;
        step();
        reset = 0;
        step();
        step();
        $display("write during clear wa=9 wd=a5a5a5a5");
        we = 1; wa = 5'd9; wd = 32'hA5A5A5A5;
        step();
        we = 0;
        #1;
        check("drop_pulse", {31'b0, drop_z}, 32'd1);
        step();
        check("drop_gone", {31'b0, drop_z}, 32'd0);
        wait_ready(cnt);
        set_ra(5'd9, 5'd9, 5'd9, 5'd9);
        #1;
        check("dropped_9_z", rd_z[0*DW +: DW], 32'h0);
        check("dropped_9_n", rd_n[3*DW +: DW], 32'h0);

        // Populate entries, then interrupt a sweep at busy cycle 20 and restart it.
        for (int i = 1; i < DEPTH; i++) begin
            we = 1; wa = AW'(i); wd = 32'hC0DE0000 | i;
            step();
        end
        we = 0;
        reset = 1;
        step();
        reset = 0;
        repeat (19) step();
        check("mid_busy", {31'b0, busy_z}, 32'd1);
        reset = 1;
        step();
        reset = 0;
        check("restart_busy", {31'b0, busy_z}, 32'd1);
        wait_ready(cnt);
        check("restart_len", cnt, 32'd32);
        set_ra(5'd1, 5'd2, 5'd30, 5'd31);
        #1;
        for (int p = 0; p < NR; p++) begin
            check($sformatf("restart_z[%0d]", p), rd_z[p*DW +: DW], 32'h0);
            check($sformatf("restart_n[%0d]", p), rd_n[p*DW +: DW], 32'h0);
        end
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
